// File: rtl/pwm.sv
// Single-ramp PWM generator. The period is 2^W-1 clocks and the duty request
// is sampled once per period so mid-period changes never truncate a pulse.
module pwm #(
  parameter int C_CLK_FRQ     = 100000000,
  parameter int C_LEVEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [C_LEVEL_WIDTH-1:0] level,
  output logic                     out
);

  localparam int unsigned C_PERIOD = (1 << C_LEVEL_WIDTH) - 1;
  localparam logic [C_LEVEL_WIDTH-1:0] C_CNT_LAST = C_LEVEL_WIDTH'(C_PERIOD - 1);

  // The clock frequency only documents the resulting PWM rate.
  generate
    if (C_CLK_FRQ <= 0 || C_LEVEL_WIDTH < 1 || C_LEVEL_WIDTH > 16) begin : g_param_check
      $error("pwm: illegal parameter values");
    end
  endgenerate

  logic [C_LEVEL_WIDTH-1:0] cnt_q, cnt_d;
  logic [C_LEVEL_WIDTH-1:0] lvl_q, lvl_d;
  logic [C_LEVEL_WIDTH-1:0] cmp;
  logic                     out_q, out_d;

  // At cnt==0 the live level is compared directly so the new duty shows up
  // one clock after capture instead of one period later.
  always_comb begin
    lvl_d = lvl_q;
    cmp   = lvl_q;
    if (cnt_q == '0) begin
      lvl_d = level;
      cmp   = level;
    end
    out_d = (cnt_q < cmp);
    cnt_d = (cnt_q == C_CNT_LAST) ? '0 : cnt_q + C_LEVEL_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      cnt_q <= '0;
      lvl_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: per-period high-time and pulse-shape checks at W=8,
// plus reset corner cases and a W=1 instance.
module tb_pwm;

  localparam int P = 255;

  logic       clk = 1'b0;
  logic       rstb;
  logic [7:0] level;
  logic       out;
  logic       level1;
  logic       out1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pwm #(.C_CLK_FRQ(100000000), .C_LEVEL_WIDTH(8)) u_pwm (
    .clk   (clk),
    .rstb  (rstb),
    .level (level),
    .out   (out)
  );

  pwm #(.C_CLK_FRQ(100000000), .C_LEVEL_WIDTH(1)) u_pwm1 (
    .clk   (clk),
    .rstb  (rstb),
    .level (level1),
    .out   (out1)
  );

  typedef struct packed {
    logic [7:0] lvl_start;
    int         change_at;
    logic [7:0] lvl_mid;
    int         n_periods;
    int         exp_first;
    int         exp_later;
  } vec_t;

  vec_t vecs[14];

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Starts at a negedge just before a period-start edge; samples all P outputs.
  task automatic apply_stimulus(input logic [7:0] lvl_start, input int change_at,
                                input logic [7:0] lvl_mid, output int highs,
                                output int first_low, output int first_out);
    highs     = 0;
    first_low = P;
    first_out = 0;
    level     = lvl_start;
    for (int k = 0; k < P; k++) begin
      if (k == change_at) level = lvl_mid;
      @(posedge clk);
      @(negedge clk);
      if (k == 0) first_out = int'(out);
      if (out === 1'b1) highs++;
      else if (first_low == P) first_low = k;
    end
  endtask

  initial begin
    int highs, first_low, first_out, bad;
    logic [6:0] pat;

    vecs[0]  = '{8'd0,   -1,  8'd0,   3, 0,   0};
    vecs[1]  = '{8'd1,   -1,  8'd1,   1, 1,   1};
    vecs[2]  = '{8'd3,   -1,  8'd3,   1, 3,   3};
    vecs[3]  = '{8'd7,   -1,  8'd7,   1, 7,   7};
    vecs[4]  = '{8'd15,  -1,  8'd15,  1, 15,  15};
    vecs[5]  = '{8'd31,  -1,  8'd31,  1, 31,  31};
    vecs[6]  = '{8'd63,  -1,  8'd63,  1, 63,  63};
    vecs[7]  = '{8'd127, -1,  8'd127, 1, 127, 127};
    vecs[8]  = '{8'd255, -1,  8'd255, 3, 255, 255};
    vecs[9]  = '{8'd64,  100, 8'd200, 2, 64,  200};
    vecs[10] = '{8'd0,   1,   8'd255, 2, 0,   255};
    vecs[11] = '{8'd200, 150, 8'd10,  2, 200, 10};
    vecs[12] = '{8'd254, -1,  8'd254, 1, 254, 254};
    vecs[13] = '{8'd128, -1,  8'd128, 1, 128, 128};

    rstb   = 1'b1;
    level  = 8'hFF;
    level1 = 1'b0;

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out !== 1'b0) bad++;
    end
    check_output("reset_hold_out_low_cycles_bad", bad, 0);
    rstb = 1'b0;

    apply_stimulus(8'hFF, -1, 8'hFF, highs, first_low, first_out);
    check_output("first_edge_after_reset_out", first_out, 1);
    check_output("after_reset_high_count", highs, 255);

    for (int v = 0; v < 14; v++) begin
      for (int p = 0; p < vecs[v].n_periods; p++) begin
        int exp_h;
        exp_h = (p == 0) ? vecs[v].exp_first : vecs[v].exp_later;
        if (p == 0)
          apply_stimulus(vecs[v].lvl_start, vecs[v].change_at, vecs[v].lvl_mid,
                         highs, first_low, first_out);
        else
          apply_stimulus(vecs[v].lvl_mid, -1, vecs[v].lvl_mid, highs, first_low, first_out);
        check_output($sformatf("vec%0d_p%0d_high_count", v, p), highs, exp_h);
        check_output($sformatf("vec%0d_p%0d_first_low", v, p), first_low, exp_h);
      end
    end

    // Reset lands on the edge where cnt==50 with a 128 duty in progress.
    level = 8'd128;
    highs = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out === 1'b1) highs++;
    end
    check_output("pre_abort_high_count", highs, 50);
    rstb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("abort_out", int'(out), 0);
    rstb = 1'b0;
    apply_stimulus(8'd128, -1, 8'd128, highs, first_low, first_out);
    check_output("restart_high_count", highs, 128);
    check_output("restart_first_low", first_low, 128);

    // W=1: out follows level one clock later.
    pat = 7'b0110101;
    for (int i = 0; i < 7; i++) begin
      level1 = pat[i];
      @(posedge clk);
      @(negedge clk);
      check_output($sformatf("w1_follow_%0d", i), int'(out1), int'(pat[i]));
    end
    level1 = 1'b1;
    rstb   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("w1_reset_out", int'(out1), 0);
    rstb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("w1_after_reset_out", int'(out1), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm.md
PWM -- requirements
Module: pwm

Interface
REQ-001 The block SHALL have parameter C_CLK_FRQ, default 100000000, meaning clock frequency in Hz; it is informational only and SHALL NOT alter behaviour.
REQ-002 The block SHALL have parameter C_LEVEL_WIDTH, default 8, meaning width W of the level input; legal range 1..16.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have port rstb, input, 1 bit, meaning a synchronous, active-high reset; the port name is kept per codebase naming and the polarity is high-active.
REQ-005 The block SHALL have port level, input, C_LEVEL_WIDTH bits, meaning the unsigned duty-cycle request, range 0..2^W-1.
REQ-006 The block SHALL have port out, output, 1 bit, meaning the PWM waveform, driven directly from a flip-flop.

Function
REQ-007 The PWM period P SHALL be 2^W-1 clock cycles, giving 100 MHz / 255 ≈ 392.2 kHz for defaults.
REQ-008 An internal W-bit counter cnt SHALL count 0,1,...,P-1 and then wrap to 0, advancing by one on every non-reset edge.
REQ-009 On every non-reset edge where cnt==0, the block SHALL capture level into an internal shadow register lvl.
REQ-010 level SHALL NOT affect out at any other time, so changes mid-period take effect only at the next period start.
REQ-011 On every non-reset edge, out SHALL be loaded with (cnt < E), where E = level when cnt==0 and E = lvl otherwise, using an unsigned W-bit compare.
REQ-012 out SHALL be high for exactly lvl cycles and low for exactly P-lvl cycles in each period.
REQ-013 Latency from the capture edge to the first cycle of the new waveform SHALL be 1 clock.
REQ-014 level=0 SHALL give out constantly 0 with no glitch pulses.
REQ-015 level=2^W-1 SHALL give out constantly 1, i.e. 100 % duty with no low cycle at the wrap.
REQ-016 With W=1 (P=1), cnt SHALL remain 0 and out SHALL follow level with a 1-clock delay.
REQ-017 The block SHALL contain no combinational path from any input to out.

Reset
REQ-018 While rstb=1 at a rising edge, the block SHALL set cnt=0, lvl=0 and out=0, overriding all other activity.
REQ-019 Reset asserted mid-period SHALL abort the period.
REQ-020 On the first non-reset edge after rstb falls, cnt SHALL be 0, so that edge captures level and starts a fresh period.
REQ-021 The block SHALL NOT rely on power-up initial values for correct operation after a reset.

Verification (W=8, P=255, 100 MHz)
REQ-022 Reset held for 20 cycles with level=0xFF SHALL keep out=0 throughout reset, and out SHALL go to 1 one clock after the first non-reset edge.
REQ-023 level=0 held for 3 periods SHALL keep out=0 on every cycle.
REQ-024 level=1 SHALL produce exactly 1 high and 254 low cycles per 255-cycle period.
REQ-025 The level sweep 3, 7, 15, 31, 63, 127 SHALL produce high times of 3, 7, 15, 31, 63, 127 cycles per 255-cycle period respectively.
REQ-026 level=255 SHALL keep out=1 continuously across at least 3 period wraps.
REQ-027 Changing level from 64 to 200 at cnt=100 SHALL finish the current period with 64 high cycles and make the next period 200 high cycles.
REQ-028 Asserting rstb for 1 cycle at cnt=50 with level=128 SHALL make out=0 on the next edge and restart a full 128-high / 127-low period after release.
